// File: rtl/l2_sumsq_accum_pkg.sv
// Shared ALU definitions for the L2-norm / RMS path: default formats, FSM
// encoding and the saturating add used by the sum-of-squares accumulator.
package l2_sumsq_accum_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 5;
    localparam int ACC_W_DEF  = 32;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic                 sat;
        logic [ACC_W_DEF-1:0] sum;
    } sat_sum_t;

    // Unsigned add that clamps to all-ones when the carry out is set.
    function automatic sat_sum_t sat_add(input logic [ACC_W_DEF-1:0] a,
                                         input logic [ACC_W_DEF-1:0] b);
        logic [ACC_W_DEF:0] wide;
        sat_sum_t           res;
        wide    = {1'b0, a} + {1'b0, b};
        res.sat = wide[ACC_W_DEF];
        res.sum = wide[ACC_W_DEF] ? {ACC_W_DEF{1'b1}} : wide[ACC_W_DEF-1:0];
        return res;
    endfunction

endpackage

// File: rtl/l2_sumsq_accum_sat_accum.sv
// Saturating unsigned accumulator with synchronous clear, enable and a sticky
// flag that records any clamp since the last clear.
module l2_sumsq_accum_sat_accum
    import l2_sumsq_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [ACC_W-1:0] i_addend,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_sat
);

    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic [ACC_W-1:0] w_sum;
    logic             w_carry;

    generate
        if (ACC_W == ACC_W_DEF) begin : g_pkg_add
            sat_sum_t w_res;
            assign w_res   = sat_add(r_acc, i_addend);
            assign w_carry = w_res.sat;
            assign w_sum   = w_res.sum;
        end else begin : g_wide_add
            logic [ACC_W:0] w_wide;
            assign w_wide  = {1'b0, r_acc} + {1'b0, i_addend};
            assign w_carry = w_wide[ACC_W];
            assign w_sum   = w_wide[ACC_W] ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_en) begin
            r_acc <= w_sum;
            if (w_carry) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign o_acc = r_acc;
    assign o_sat = r_sat;

endmodule

// File: rtl/l2_sumsq_accum.sv
// Sum-of-squares front end for the square-root unit: squares a stream of
// signed elements and emits one saturated sum per vector.
module l2_sumsq_accum
    import l2_sumsq_accum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_last,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ACC_W-1:0]  o_out_sum,
    output logic [CNT_W-1:0]  o_out_count,
    output logic              o_out_sat
);

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_accept;
    logic                       w_handshake;
    logic signed [DATA_W-1:0]   w_in_s;
    logic signed [2*DATA_W-1:0] w_sq_s;
    logic [2*DATA_W-1:0]        r_sq;
    logic                       r_sq_valid;
    logic                       r_sq_last;
    logic                       r_last_added;
    logic [CNT_W-1:0]           r_count;
    logic                       w_unused_fmt;

    // FRAC_W only fixes the output format (2*FRAC_W fraction bits).
    assign w_unused_fmt = (2 * FRAC_W <= ACC_W);

    assign w_accept    = i_in_valid && o_in_ready;
    assign w_handshake = o_out_valid && i_out_ready;

    // Full-width signed product: the most-negative input squares without overflow.
    assign w_in_s = i_in_data;
    assign w_sq_s = (2*DATA_W)'(w_in_s) * (2*DATA_W)'(w_in_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq         <= '0;
            r_sq_valid   <= 1'b0;
            r_sq_last    <= 1'b0;
            r_last_added <= 1'b0;
        end else begin
            r_sq_valid   <= w_accept;
            r_last_added <= r_sq_valid && r_sq_last;
            if (w_accept) begin
                r_sq      <= $unsigned(w_sq_s);
                r_sq_last <= i_in_last;
            end
        end
    end

    l2_sumsq_accum_sat_accum #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_handshake),
        .i_en     (r_sq_valid),
        .i_addend (ACC_W'(r_sq)),
        .o_acc    (o_out_sum),
        .o_sat    (o_out_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_handshake) begin
            r_count <= '0;
        end else if (r_sq_valid && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_out_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DRAIN waits one extra cycle so the final square is already in the sum.
    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                o_in_ready = 1'b1;
                if (i_in_valid && i_in_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_last_added) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_next = ST_ACCUM;
                end
            end
            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase
    end

endmodule

// File: tb/tb_l2_sumsq_accum.sv
// Randomised scoreboard bench for l2_sumsq_accum: a driver pushes the
// expected per-vector result, a monitor checks every cycle the DUT holds one.
module tb_l2_sumsq_accum;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int CNT_W  = 8;
    localparam longint SUM_MAX = 64'h0000_0000_FFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_in_valid = 1'b0;
    logic              o_in_ready;
    logic [DATA_W-1:0] i_in_data = '0;
    logic              i_in_last = 1'b0;
    logic              o_out_valid;
    logic              i_out_ready = 1'b1;
    logic [ACC_W-1:0]  o_out_sum;
    logic [CNT_W-1:0]  o_out_count;
    logic              o_out_sat;

    typedef struct {
        longint sum;
        int     count;
        bit     sat;
        int     acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rmode = 0;
    bit   prev_valid = 1'b0;
    bit   chk_ready_next = 1'b0;

    l2_sumsq_accum dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .i_in_last   (i_in_last),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_sum   (o_out_sum),
        .o_out_count (o_out_count),
        .o_out_sat   (o_out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: running sum of squares, clamped at 2^32-1 with a sticky flag.
    function automatic exp_t model(input int vals[$]);
        exp_t   e;
        longint s = 0;
        bit     sat = 1'b0;
        foreach (vals[i]) begin
            s = s + longint'(vals[i]) * longint'(vals[i]);
            if (s > SUM_MAX) begin
                s   = SUM_MAX;
                sat = 1'b1;
            end
        end
        e.sum     = s;
        e.sat     = sat;
        e.count   = (vals.size() > 255) ? 255 : vals.size();
        e.acc_cyc = 0;
        return e;
    endfunction

    // out_ready policy: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       i_out_ready = 1'($urandom_range(0, 1));
                2:       i_out_ready = 1'b0;
                default: i_out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid     = 1'b0;
                chk_ready_next = 1'b0;
            end else begin
                if (chk_ready_next) begin
                    check("post_hs_in_ready", o_in_ready, 1);
                    check("post_hs_out_valid", o_out_valid, 0);
                    chk_ready_next = 1'b0;
                end
                if (o_out_valid) begin
                    if (sb.size() == 0) begin
                        check("spurious_out_valid", o_out_valid, 0);
                    end else begin
                        if (!prev_valid) begin
                            check("latency", cyc - sb[0].acc_cyc, 2);
                        end
                        check("out_sum", o_out_sum, sb[0].sum);
                        check("out_count", o_out_count, sb[0].count);
                        check("out_sat", o_out_sat, sb[0].sat);
                        check("hold_in_ready", o_in_ready, 0);
                        if (i_out_ready) begin
                            void'(sb.pop_front());
                            chk_ready_next = 1'b1;
                        end
                    end
                end
                prev_valid = o_out_valid;
            end
        end
    end

    task automatic send_vec(input int vals[$], input int gap, input bit mark_last);
        exp_t e;
        for (int i = 0; i < vals.size(); i++) begin
            int waited = 0;
            i_in_valid = 1'b1;
            i_in_data  = DATA_W'(vals[i]);
            i_in_last  = mark_last && (i == vals.size() - 1);
            while (o_in_ready !== 1'b1 && waited < 2000) begin
                @(posedge clk);
                #1;
                waited++;
            end
            if (waited >= 2000) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=no_ready required=ready (cycle %0d)", cyc);
                i_in_valid = 1'b0;
                return;
            end
            if (i_in_last) begin
                e         = model(vals);
                e.acc_cyc = cyc + 1;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            i_in_valid = 1'b0;
            i_in_data  = DATA_W'($urandom);
            i_in_last  = 1'($urandom_range(0, 1));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        i_in_last = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || o_out_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!o_out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL valid_timeout actual=0 required=1");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, o_in_ready, 1);
        check({tag, "_out_valid"}, o_out_valid, 0);
        check({tag, "_out_sum"}, o_out_sum, 0);
        check({tag, "_out_count"}, o_out_count, 0);
        check({tag, "_out_sat"}, o_out_sat, 0);
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        sb.delete();
        @(posedge clk);
        #1;
        check_reset_outputs({tag, "_held"});
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int v[$];
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        v = {96, 128};
        send_vec(v, 0, 1'b1);
        wait_drain();

        v = {-64};
        send_vec(v, 0, 1'b1);
        wait_drain();

        v.delete();
        repeat (5) v.push_back(-32768);
        send_vec(v, 0, 1'b1);
        wait_drain();

        rmode = 2;
        v = {32, 32};
        send_vec(v, 0, 1'b1);
        wait_valid();
        repeat (10) @(posedge clk);
        #1;
        rmode = 0;
        v = {64};
        send_vec(v, 0, 1'b1);
        wait_drain();

        v = {32, 32, 32};
        send_vec(v, 2, 1'b1);
        wait_drain();

        v = {32, 32};
        send_vec(v, 0, 1'b0);
        pulse_reset("rst_mid");
        v = {32};
        send_vec(v, 0, 1'b1);
        wait_drain();

        rmode = 2;
        v = {100, -200};
        send_vec(v, 0, 1'b1);
        wait_valid();
        pulse_reset("rst_hold");
        rmode = 0;
        v = {-32};
        send_vec(v, 1, 1'b1);
        wait_drain();

        v.delete();
        repeat (300) v.push_back(3);
        send_vec(v, 0, 1'b1);
        wait_drain();

        rmode = 1;
        for (int n = 0; n < 30; n++) begin
            int len = $urandom_range(1, 6);
            v.delete();
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    v.push_back(int'($signed(16'($urandom))));
                end else begin
                    v.push_back(int'($urandom_range(0, 4000)) - 2000);
                end
            end
            send_vec(v, $urandom_range(0, 2), 1'b1);
        end
        rmode = 0;
        wait_drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
